// File: rtl/ucode_fsm_if.sv
// Bundle between the datapath, the table loader and ucode_fsm.
// Carries the condition inputs, programming port, control outputs and status flags.
interface ucode_fsm_if #(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 3
);
  localparam int unsigned AW = IN_W + STATE_W;
  localparam int unsigned WW = STATE_W + OUT_W;

  logic [IN_W-1:0]    A;
  logic               run;
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [WW-1:0]      prog_data;
  logic               err_clr;
  logic [OUT_W-1:0]   c;
  logic [STATE_W-1:0] state;
  logic               miss;
  logic               wr_err;

  modport master (
    output A, run, prog_we, prog_addr, prog_data, err_clr,
    input  c, state, miss, wr_err
  );

  modport slave (
    input  A, run, prog_we, prog_addr, prog_data, err_clr,
    output c, state, miss, wr_err
  );
endinterface

// File: rtl/ucode_fsm.sv
// Table-driven state machine: {A, state} indexes a writable control store
// that supplies the next state and control outputs; sticky miss/write-error flags.
module ucode_fsm #(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 3,
  parameter int unsigned REG_OUT = 0
) (
  input  logic       clk,
  input  logic       res,
  ucode_fsm_if.slave bus
);
  localparam int unsigned AW    = IN_W + STATE_W;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned WW    = STATE_W + OUT_W;

  logic [WW-1:0]      mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [STATE_W-1:0] state_q, state_d;
  logic               miss_q, miss_d;
  logic               wr_err_q, wr_err_d;

  logic [AW-1:0]      addr_c;
  logic [WW-1:0]      word_c;
  logic               hit_c;
  logic               wr_en_c;
  logic [OUT_W-1:0]   out_c;

  assign addr_c  = {bus.A, state_q};
  assign word_c  = mem_q[addr_c];
  assign hit_c   = valid_q[addr_c];
  assign out_c   = hit_c ? word_c[OUT_W-1:0] : '0;
  assign wr_en_c = bus.prog_we & ~bus.run;

  // Next state and sticky flags; a set in the same cycle overrides err_clr.
  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    wr_err_d = wr_err_q;
    if (bus.err_clr) begin
      miss_d   = 1'b0;
      wr_err_d = 1'b0;
    end
    if (bus.run) begin
      if (hit_c) begin
        state_d = word_c[WW-1:OUT_W];
      end else begin
        miss_d = 1'b1;
      end
      if (bus.prog_we) begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= '0;
      valid_q  <= '0;
      miss_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      wr_err_q <= wr_err_d;
      if (wr_en_c) begin
        valid_q[bus.prog_addr] <= 1'b1;
      end
    end
  end

  // Store data carries no reset; the valid bits alone gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [OUT_W-1:0] c_q;
      always_ff @(posedge clk or negedge res) begin
        if (!res) begin
          c_q <= '0;
        end else if (bus.run) begin
          c_q <= out_c;
        end
      end
      assign bus.c = c_q;
    end else begin : g_comb_out
      assign bus.c = out_c;
    end
  endgenerate

  assign bus.state  = state_q;
  assign bus.miss   = miss_q;
  assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_ucode_fsm.sv
// Bench for ucode_fsm: combinational- and registered-output instances driven in
// lockstep, checked against a table model through an expected-value queue.
module tb_ucode_fsm;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned IN_W    = 2;
  localparam int unsigned OUT_W   = 3;
  localparam int unsigned AW      = IN_W + STATE_W;
  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned WW      = STATE_W + OUT_W;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic [IN_W-1:0] a;
  logic            run;
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [WW-1:0]   prog_data;
  logic            err_clr;

  ucode_fsm_if #(.STATE_W(STATE_W), .IN_W(IN_W), .OUT_W(OUT_W)) if0 ();
  ucode_fsm_if #(.STATE_W(STATE_W), .IN_W(IN_W), .OUT_W(OUT_W)) if1 ();

  assign if0.A = a;  assign if0.run = run;  assign if0.prog_we = prog_we;
  assign if0.prog_addr = prog_addr;  assign if0.prog_data = prog_data;  assign if0.err_clr = err_clr;
  assign if1.A = a;  assign if1.run = run;  assign if1.prog_we = prog_we;
  assign if1.prog_addr = prog_addr;  assign if1.prog_data = prog_data;  assign if1.err_clr = err_clr;

  ucode_fsm #(.STATE_W(STATE_W), .IN_W(IN_W), .OUT_W(OUT_W), .REG_OUT(0)) dut0 (
    .clk(clk), .res(res), .bus(if0.slave));
  ucode_fsm #(.STATE_W(STATE_W), .IN_W(IN_W), .OUT_W(OUT_W), .REG_OUT(1)) dut1 (
    .clk(clk), .res(res), .bus(if1.slave));

  typedef struct packed {
    logic [STATE_W-1:0] s0;
    logic [STATE_W-1:0] s1;
    logic [OUT_W-1:0]   c0;
    logic [OUT_W-1:0]   c1;
    logic               m0;
    logic               m1;
    logic               w0;
    logic               w1;
  } obs_t;

  obs_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model of the control store and flags
  logic [WW-1:0]      m_mem [DEPTH];
  bit                 m_valid [DEPTH];
  logic [STATE_W-1:0] m_state;
  logic [OUT_W-1:0]   m_creg;
  bit                 m_miss, m_werr;

  function automatic obs_t observed();
    obs_t o;
    o = '{s0: if0.state, s1: if1.state, c0: if0.c, c1: if1.c,
          m0: if0.miss, m1: if1.miss, w0: if0.wr_err, w1: if1.wr_err};
    return o;
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    logic [AW-1:0]    ad;
    logic [OUT_W-1:0] cc;
    ad = {a, m_state};
    cc = m_valid[ad] ? m_mem[ad][OUT_W-1:0] : '0;
    e = '{s0: m_state, s1: m_state, c0: cc, c1: m_creg,
          m0: m_miss, m1: m_miss, w0: m_werr, w1: m_werr};
    return e;
  endfunction

  task automatic m_reset();
    m_state = '0;
    m_creg  = '0;
    m_miss  = 1'b0;
    m_werr  = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
  endtask

  // Advance the model for the coming edge, queue the expectation, cross the edge.
  task automatic tick();
    logic [AW-1:0] ad;
    bit            hit;
    logic [WW-1:0] w;
    ad  = {a, m_state};
    hit = m_valid[ad];
    w   = m_mem[ad];
    if (err_clr) begin m_miss = 1'b0; m_werr = 1'b0; end
    if (run) begin
      if (hit) m_state = w[WW-1:OUT_W];
      else     m_miss  = 1'b1;
      m_creg = hit ? w[OUT_W-1:0] : '0;
      if (prog_we) m_werr = 1'b1;
    end else if (prog_we) begin
      m_mem[prog_addr]   = prog_data;
      m_valid[prog_addr] = 1'b1;
    end
    sb.push_back(expect_now());
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a = '0; run = 1'b0; prog_we = 1'b0; err_clr = 1'b0;
    prog_addr = '0; prog_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    res = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    idle_inputs();
    res = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    got = observed(); total++;
    if (got !== obs_t'(0)) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, obs_t'(0)); end
    @(negedge clk);
    res = 1'b1;
    run = 1'b1; a = '0;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_lookup got=%h exp=%h", got, exp); end
    total++;
    if (if0.miss !== 1'b1 || if0.state !== 3'd0) begin
      bad++; $display("FAIL reset_miss got miss=%b state=%0d exp miss=1 state=0", if0.miss, if0.state);
    end
    err_clr = 1'b1;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clr_vs_set got=%h exp=%h", got, exp); end
    total++;
    if (if0.miss !== 1'b1) begin bad++; $display("FAIL clr_set_wins got=%b exp=1", if0.miss); end
    run = 1'b0;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clr_only got=%h exp=%h", got, exp); end
    total++;
    if (if0.miss !== 1'b0) begin bad++; $display("FAIL clr_miss got=%b exp=0", if0.miss); end
    err_clr = 1'b0;
  endtask

  task automatic test_program();
    obs_t got, exp;
    logic [AW-1:0] addrs [3];
    logic [WW-1:0] datas [3];
    addrs = '{5'd0, 5'd2, 5'd10};
    datas = '{6'h13, 6'h30, 6'h28};
    run = 1'b0; a = '0; prog_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prog_addr = addrs[i]; prog_data = datas[i];
      tick();
      got = observed(); exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL prog_wr%0d got=%h exp=%h", i, got, exp); end
    end
    prog_we = 1'b0;
    total++;
    if (if0.c !== 3'b011) begin bad++; $display("FAIL comb_c_s0 got=%b exp=011", if0.c); end
    run = 1'b1;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL run_edge1 got=%h exp=%h", got, exp); end
    total++;
    if (if0.state !== 3'd2 || if1.c !== 3'b011) begin
      bad++; $display("FAIL regout_edge1 got state=%0d c=%b exp state=2 c=011", if0.state, if1.c);
    end
    run = 1'b0; a = 2'd1;
    #1;
    total++;
    if (if0.c !== 3'b000 || if1.c !== 3'b011) begin
      bad++; $display("FAIL a1_at_s2 got c0=%b c1=%b exp c0=000 c1=011", if0.c, if1.c);
    end
    a = 2'd0; run = 1'b1;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL run_edge2 got=%h exp=%h", got, exp); end
    total++;
    if (if0.state !== 3'd6 || if1.c !== 3'b000) begin
      bad++; $display("FAIL regout_edge2 got state=%0d c=%b exp state=6 c=000", if0.state, if1.c);
    end
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = observed(); exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL hold%0d got=%h exp=%h", i, got, exp); end
    end
    run = 1'b1;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL miss_s6 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_write_during_run();
    obs_t got, exp;
    do_reset();
    prog_we = 1'b1;
    prog_addr = 5'd0; prog_data = 6'h13; tick(); void'(sb.pop_front());
    prog_addr = 5'd2; prog_data = 6'h28; tick(); void'(sb.pop_front());
    run = 1'b1; prog_addr = 5'd5; prog_data = 6'h12;
    for (int i = 0; i < 3; i++) begin
      tick();
      prog_we = 1'b0;
      got = observed(); exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL wr_run%0d got=%h exp=%h", i, got, exp); end
      if (i == 0) begin
        total++;
        if (if0.wr_err !== 1'b1 || if0.state !== 3'd2) begin
          bad++; $display("FAIL wr_err_set got wr_err=%b state=%0d exp 1/2", if0.wr_err, if0.state);
        end
      end
    end
    total++;
    if (if0.miss !== 1'b1 || if0.state !== 3'd5) begin
      bad++; $display("FAIL dropped_write got miss=%b state=%0d exp 1/5", if0.miss, if0.state);
    end
  endtask

  task automatic test_overwrite_wrap();
    obs_t got, exp;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clr_new_miss got=%h exp=%h", got, exp); end
    total++;
    if (if0.miss !== 1'b1 || if0.wr_err !== 1'b0) begin
      bad++; $display("FAIL clr_new_miss_flags got miss=%b wr_err=%b exp 1/0", if0.miss, if0.wr_err);
    end
    run = 1'b0; prog_we = 1'b1;
    prog_addr = 5'd0; prog_data = 6'h3F; tick(); void'(sb.pop_front());
    prog_addr = 5'd5; prog_data = 6'h01; tick(); void'(sb.pop_front());
    prog_addr = 5'd7; prog_data = 6'h05; tick(); void'(sb.pop_front());
    prog_we = 1'b0; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      got = observed(); exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL wrap%0d got=%h exp=%h", i, got, exp); end
      if (i == 1) begin
        total++;
        if (if0.state !== 3'd7 || if1.c !== 3'b111) begin
          bad++; $display("FAIL overwrite got state=%0d c=%b exp 7/111", if0.state, if1.c);
        end
      end
      if (i == 2) begin
        total++;
        if (if0.state !== 3'd0 || if1.c !== 3'b101) begin
          bad++; $display("FAIL wrap7 got state=%0d c=%b exp 0/101", if0.state, if1.c);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    #2;
    res = 1'b0;
    #1;
    total++;
    if (if0.state !== 3'd0 || if0.c !== 3'd0 || if1.c !== 3'd0 || if1.state !== 3'd0) begin
      bad++; $display("FAIL async_reset got s=%0d c0=%b c1=%b exp 0/000/000", if0.state, if0.c, if1.c);
    end
    m_reset();
    @(negedge clk);
    res = 1'b1;
    run = 1'b1; a = '0;
    tick();
    got = observed(); exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL post_reset got=%h exp=%h", got, exp); end
    total++;
    if (if0.miss !== 1'b1 || if0.state !== 3'd0) begin
      bad++; $display("FAIL post_reset_miss got miss=%b state=%0d exp 1/0", if0.miss, if0.state);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    do_reset();
    prog_we = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_addr = AW'(i);
      prog_data = WW'($urandom_range(0, (1 << WW) - 1));
      tick(); void'(sb.pop_front());
    end
    for (int i = 0; i < 300; i++) begin
      a         = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      run       = ($urandom_range(0, 3) != 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = AW'($urandom_range(0, int'(DEPTH) - 1));
      prog_data = WW'($urandom_range(0, (1 << WW) - 1));
      err_clr   = ($urandom_range(0, 7) == 0);
      tick();
      got = observed(); exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL rand%0d got=%h exp=%h", i, got, exp); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_program();
    test_write_during_run();
    test_overwrite_wrap();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
